// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson (twisted-ring) count links.
// Provides the lock FSM state type, the default word width, and pure
// helpers that classify a Johnson word and map it to its sequence index.
package johnson_pkg;

  // Default Johnson word width; the sequence has 2*JC_N states.
  localparam int unsigned JC_N    = 4;
  // Widest word the helper functions accept; narrower words are zero-extended.
  localparam int unsigned JC_NMAX = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } jc_state_e;

  // Legal iff at most one adjacent-bit transition among the low n bits.
  function automatic logic jc_legal(input logic [JC_NMAX-1:0] word,
                                    input int unsigned        n);
    int unsigned diffs;
    diffs = 0;
    for (int unsigned i = 0; i < JC_NMAX - 1; i++) begin
      if ((i + 1 < n) && (word[i] ^ word[i+1])) diffs++;
    end
    return (diffs <= 1);
  endfunction

  // Sequence index: ones fill from the MSB for the first half, then drain.
  function automatic int unsigned jc_index(input logic [JC_NMAX-1:0] word,
                                           input int unsigned        n);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < JC_NMAX; i++) begin
      if ((i < n) && word[i]) ones++;
    end
    if (word[n-1] || (ones == 0)) return ones;
    return 2 * n - ones;
  endfunction

endpackage

// File: rtl/johnson_word_decode.sv
// Combinational Johnson word classifier.
// Ports: code (N-bit Johnson word) -> legal_c (word is a valid code),
//        index_c (sequence index 0..2N-1, forced to 0 when illegal).
module johnson_word_decode
  import johnson_pkg::*;
#(
  parameter int unsigned N = JC_N
) (
  input  logic [N-1:0]             code,
  output logic                     legal_c,
  output logic [$clog2(2*N)-1:0]   index_c
);

  localparam int unsigned IW = $clog2(2 * N);

  logic [JC_NMAX-1:0] word_ext;

  assign word_ext = JC_NMAX'(code);

  always_comb begin
    legal_c = jc_legal(word_ext, N);
    index_c = '0;
    if (legal_c) index_c = IW'(jc_index(word_ext, N));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson count receiver: decodes each word to its binary index, checks
// legality and continuity, and tracks lock on a well-formed count stream.
// Ports: clk, reset (sync, active-high); in_valid/in_code input word;
//        out_valid/out_index/out_illegal/out_seq_err per-word results one
//        cycle later; locked lock status; err_count saturating error tally.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned N        = JC_N,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERRW     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_code,
  output logic                     out_valid,
  output logic [$clog2(2*N)-1:0]   out_index,
  output logic                     out_illegal,
  output logic                     out_seq_err,
  output logic                     locked,
  output logic [ERRW-1:0]          err_count
);

  localparam int unsigned IW       = $clog2(2 * N);
  localparam int unsigned RW       = $clog2(LOCK_CNT + 1);
  localparam int unsigned IDX_LAST = 2 * N - 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_CNT - 1);

  jc_state_e       state, state_n;
  logic [IW-1:0]   prev, prev_n;
  logic [RW-1:0]   run, run_n;
  logic [IW-1:0]   index_n;
  logic            illegal_n, seq_err_n;

  logic            legal_c;
  logic [IW-1:0]   index_c;
  logic [IW-1:0]   succ_c;
  logic            is_hold_c, is_succ_c;

  johnson_word_decode #(.N(N)) u_decode (
    .code    (in_code),
    .legal_c (legal_c),
    .index_c (index_c)
  );

  // Expected next index, wrapping 2N-1 back to 0 for any N.
  assign succ_c    = (prev == IW'(IDX_LAST)) ? '0 : prev + IW'(1);
  assign is_hold_c = (index_c == prev);
  assign is_succ_c = (index_c == succ_c);

  // Next-state and per-word flag logic; idle cycles leave everything as is.
  always_comb begin
    state_n   = state;
    prev_n    = prev;
    run_n     = run;
    index_n   = '0;
    illegal_n = 1'b0;
    seq_err_n = 1'b0;
    if (in_valid) begin
      if (!legal_c) begin
        illegal_n = 1'b1;
        state_n   = HUNT;
      end else begin
        index_n = index_c;
        prev_n  = index_c;
        case (state)
          HUNT: begin
            state_n = VERIFY;
            run_n   = '0;
          end
          VERIFY: begin
            if (is_hold_c) begin
              run_n = run;
            end else if (is_succ_c) begin
              run_n = run + RW'(1);
              if (run == RUN_LAST) state_n = LOCKED;
            end else begin
              run_n = '0;
            end
          end
          LOCKED: begin
            if (!is_hold_c && !is_succ_c) begin
              seq_err_n = 1'b1;
              state_n   = VERIFY;
              run_n     = '0;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  // State, history and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      prev        <= '0;
      run         <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_illegal <= 1'b0;
      out_seq_err <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      run         <= run_n;
      out_valid   <= in_valid;
      out_index   <= index_n;
      out_illegal <= illegal_n;
      out_seq_err <= seq_err_n;
      locked      <= (state_n == LOCKED);
      if ((illegal_n || seq_err_n) && (err_count != {ERRW{1'b1}}))
        err_count <= err_count + ERRW'(1);
    end
  end

endmodule
